// File: rtl/final_schematic_pkg.sv
// Shared constants and types for the parking-meter tariff block.
package final_schematic_pkg;

   localparam int unsigned D_W     = 4;
   localparam int unsigned FEE_W   = 5;
   localparam int unsigned EXC_W   = 6;
   localparam int unsigned ID_W    = 45;
   localparam int unsigned PROD_W  = 8;

   localparam int unsigned UNIT_30M = 1;
   localparam int unsigned UNIT_1H  = 2;
   localparam int unsigned UNIT_2H  = 4;

   localparam int unsigned FEE_MAX = 31;

   // Encoding matches {ClientB, ClientA}; NONE and BOTH are invalid selections.
   typedef enum logic [1:0] {
      CLIENT_NONE = 2'b00,
      CLIENT_A    = 2'b01,
      CLIENT_B    = 2'b10,
      CLIENT_BOTH = 2'b11
   } client_e;

   typedef struct packed {
      logic             valid;
      logic [FEE_W-1:0] fee;
   } fee_res_t;

   function automatic logic [PROD_W-1:0] saturate_fee(input logic [PROD_W-1:0] prod);
      if (prod > PROD_W'(FEE_MAX)) return PROD_W'(FEE_MAX);
      return prod;
   endfunction

endpackage

// File: rtl/final_schematic_if.sv
// Front-panel inputs and display outputs of the tariff block.
interface final_schematic_if;
   import final_schematic_pkg::*;

   logic              ClientA;
   logic              ClientB;
   logic              Button30Min;
   logic              Button1Hour;
   logic              Button2Hours;
   logic [ID_W-1:0]   StudentNumbers;
   logic [D_W-1:0]    D;
   logic [FEE_W-1:0]  ValueToPay;
   logic              P_;
   logic [EXC_W-1:0]  Excess5;

   modport master (
      output ClientA, ClientB, Button30Min, Button1Hour, Button2Hours,
      input  StudentNumbers, D, ValueToPay, P_, Excess5
   );

   modport slave (
      input  ClientA, ClientB, Button30Min, Button1Hour, Button2Hours,
      output StudentNumbers, D, ValueToPay, P_, Excess5
   );
endinterface

// File: rtl/final_schematic_fee_calc.sv
// Combinational fee: client select and duration to validity and saturated fee.
module fee_calc
   import final_schematic_pkg::*;
#(
   parameter int unsigned RATE_A = 3,
   parameter int unsigned RATE_B = 4
) (
   input  client_e        client,
   input  logic [D_W-1:0] d,
   output fee_res_t       res_c
);

   logic [PROD_W-1:0] rate;
   logic [PROD_W-1:0] prod;

   // Simultaneous selects are invalid rather than prioritised.
   always_comb begin
      rate        = '0;
      res_c.valid = 1'b0;
      unique case (client)
         CLIENT_A: begin
            rate        = PROD_W'(RATE_A);
            res_c.valid = 1'b1;
         end
         CLIENT_B: begin
            rate        = PROD_W'(RATE_B);
            res_c.valid = 1'b1;
         end
         default: begin
            rate        = '0;
            res_c.valid = 1'b0;
         end
      endcase
   end

   always_comb begin
      prod      = PROD_W'(d) * rate;
      res_c.fee = FEE_W'(saturate_fee(prod));
   end

endmodule

// File: rtl/final_schematic.sv
// Parking-meter tariff top: duration decode, fee lookup and registered display outputs.
module final_schematic
   import final_schematic_pkg::*;
#(
   parameter logic [ID_W-1:0] STUDENT_NUMBERS = 45'h0,
   parameter int unsigned     RATE_A          = 3,
   parameter int unsigned     RATE_B          = 4,
   parameter int unsigned     EXCESS_OFFSET   = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   final_schematic_if.slave  bus
);

   client_e          client;
   logic [D_W-1:0]   d_c;
   fee_res_t         res_c;
   logic             pay_due_c;
   logic [EXC_W-1:0] excess_c;

   // Buttons are additive half-hour units.
   always_comb begin
      d_c = '0;
      if (bus.Button30Min)  d_c = d_c + D_W'(UNIT_30M);
      if (bus.Button1Hour)  d_c = d_c + D_W'(UNIT_1H);
      if (bus.Button2Hours) d_c = d_c + D_W'(UNIT_2H);
   end

   assign client = client_e'({bus.ClientB, bus.ClientA});

   fee_calc #(
      .RATE_A (RATE_A),
      .RATE_B (RATE_B)
   ) u_fee_calc (
      .client (client),
      .d      (d_c),
      .res_c  (res_c)
   );

   assign pay_due_c = res_c.valid && (d_c != '0);
   assign excess_c  = EXC_W'(res_c.fee) + EXC_W'(EXCESS_OFFSET);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.D          <= '0;
         bus.ValueToPay <= '0;
         bus.P_         <= 1'b1;
         bus.Excess5    <= EXC_W'(EXCESS_OFFSET);
      end else begin
         bus.D          <= d_c;
         bus.ValueToPay <= res_c.fee;
         bus.P_         <= ~pay_due_c;
         bus.Excess5    <= excess_c;
      end
   end

   // ID word is a wired constant, independent of reset.
   assign bus.StudentNumbers = STUDENT_NUMBERS;

endmodule

// File: tb/tb_final_schematic.sv
// Directed bench for final_schematic: reset, full input sweep, invalid clients, saturation, async reset.
module tb_final_schematic;
   import final_schematic_pkg::*;

   localparam logic [ID_W-1:0] ID_WORD = 45'h1A2B_3C4D_5E6;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;

   final_schematic_if bus1 ();
   final_schematic_if bus2 ();

   final_schematic #(
      .STUDENT_NUMBERS (ID_WORD),
      .RATE_A          (3),
      .RATE_B          (4),
      .EXCESS_OFFSET   (5)
   ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   final_schematic #(
      .STUDENT_NUMBERS (ID_WORD),
      .RATE_A          (3),
      .RATE_B          (5),
      .EXCESS_OFFSET   (5)
   ) u_dut_sat (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_dut1(input string tag, input int d, input int v, input int p, input int e);
      check({tag, ".D"},          64'(bus1.D),          64'(d));
      check({tag, ".ValueToPay"}, 64'(bus1.ValueToPay), 64'(v));
      check({tag, ".P_"},         64'(bus1.P_),         64'(p));
      check({tag, ".Excess5"},    64'(bus1.Excess5),    64'(e));
   endtask

   task automatic drive(input logic a, input logic b, input logic m30, input logic h1, input logic h2);
      bus1.ClientA = a;  bus1.ClientB = b;
      bus1.Button30Min = m30; bus1.Button1Hour = h1; bus1.Button2Hours = h2;
      bus2.ClientA = a;  bus2.ClientB = b;
      bus2.Button30Min = m30; bus2.Button1Hour = h1; bus2.Button2Hours = h2;
   endtask

   // Drive at the falling edge, sample 1 time unit after the next rising edge.
   task automatic apply(input logic a, input logic b, input logic m30, input logic h1, input logic h2);
      @(negedge clk);
      drive(a, b, m30, h1, h2);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int d_exp, rate_exp, fee_exp, p_exp;
      logic [4:0] v;
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Reset held with random inputs
      repeat (3) begin
         @(negedge clk);
         drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      end
      @(posedge clk);
      #1;
      check_dut1("reset", 0, 0, 1, 5);
      check("reset.ID", 64'(bus1.StudentNumbers), 64'(ID_WORD));

      // Release, A with 2 h
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      check_dut1("a_2h", 4, 12, 0, 17);

      // Directed spot checks
      apply(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      check_dut1("b_all", 7, 28, 0, 33);
      apply(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      check_dut1("both_1h", 2, 0, 1, 5);
      apply(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      check_dut1("none_30m", 1, 0, 1, 5);
      apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      check_dut1("a_nobtn", 0, 0, 1, 5);
      apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      check_dut1("b_nobtn", 0, 0, 1, 5);

      // Full sweep of {A, B, 30m, 1h, 2h}
      for (int i = 0; i < 32; i++) begin
         v = 5'(i);
         apply(v[4], v[3], v[2], v[1], v[0]);
         d_exp    = int'(v[2]) + 2 * int'(v[1]) + 4 * int'(v[0]);
         rate_exp = (v[4] && !v[3]) ? 3 : ((v[3] && !v[4]) ? 4 : 0);
         fee_exp  = d_exp * rate_exp;
         if (fee_exp > 31) fee_exp = 31;
         p_exp    = (rate_exp != 0 && d_exp != 0) ? 0 : 1;
         check_dut1($sformatf("sweep%0d", i), d_exp, fee_exp, p_exp, fee_exp + 5);
      end

      // Saturation with RATE_B=5
      apply(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      check("sat.D",          64'(bus2.D),          64'(7));
      check("sat.ValueToPay", 64'(bus2.ValueToPay), 64'(31));
      check("sat.Excess5",    64'(bus2.Excess5),    64'(36));
      check("sat.P_",         64'(bus2.P_),         64'(0));
      apply(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      check("sat6.ValueToPay", 64'(bus2.ValueToPay), 64'(30));

      // Asynchronous reset between edges while payment due
      apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      check_dut1("pre_async", 5, 15, 0, 20);
      #2;
      rst_n = 1'b0;
      #1;
      check_dut1("async_rst", 0, 0, 1, 5);
      check("async_rst.ID", 64'(bus1.StudentNumbers), 64'(ID_WORD));
      check("async_rst.sat", 64'(bus2.ValueToPay), 64'(0));

      // Recovery after reset release
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      @(posedge clk);
      #1;
      check_dut1("recover", 2, 8, 0, 13);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
